// File: rtl/sma_stream_add.sv
// Stream engine between the sequential memory access unit's read and write FIFOs:
// adds a latched 32-bit constant to every lane of each word, preserving order.
module sma_stream_add #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  i_uclk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [31:0]           i_len,
  input  logic [31:0]           i_addend,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_rd,
  input  logic                  i_vld,
  input  logic [32*LANES-1:0]   i_dout,
  output logic                  o_wr,
  input  logic                  i_full,
  output logic [32*LANES-1:0]   o_din
);

  localparam int unsigned DW = 32 * LANES;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DepthC = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          r_state, w_state_next;
  logic [31:0]     r_len, r_addend, r_rd_cnt, r_wr_cnt;
  logic            r_outstanding, r_pipe_valid, r_err;
  logic [DW-1:0]   r_pipe_data;
  logic [DW-1:0]   r_buf [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_start, w_rd, w_wr, w_accept, w_stray;
  logic [CW:0]     w_occ;
  logic [DW-1:0]   w_sum;
  logic [PW-1:0]   w_wptr_next, w_rptr_next;

  assign w_start  = (r_state == StIdle) && i_start;
  assign w_accept = i_vld && r_outstanding;
  assign w_stray  = i_vld && !r_outstanding;

  // Everything between issue and write-out counts against the buffer size, so a
  // push can never find the buffer full.
  assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding} + {{CW{1'b0}}, r_pipe_valid};
  assign w_rd  = (r_state == StRun) && (r_rd_cnt < r_len) && (w_occ < DepthC);
  assign w_wr  = (r_state == StRun) && (r_count != '0) && !i_full;

  assign w_wptr_next = (r_wptr == LastPtr) ? '0 : r_wptr + PW'(1);
  assign w_rptr_next = (r_rptr == LastPtr) ? '0 : r_rptr + PW'(1);

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_sum[32*i +: 32] = i_dout[32*i +: 32] + r_addend;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_next = (i_len == 32'd0) ? StFin : StRun;
      end
      // Leave on the final write so done lands in the cycle right after it.
      StRun: begin
        if (w_wr && (r_wr_cnt + 32'd1 == r_len)) w_state_next = StFin;
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_uclk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_len         <= '0;
      r_addend      <= '0;
      r_rd_cnt      <= '0;
      r_wr_cnt      <= '0;
      r_outstanding <= 1'b0;
      r_pipe_valid  <= 1'b0;
      r_pipe_data   <= '0;
      r_err         <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_start) begin
        r_len    <= i_len;
        r_addend <= i_addend;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_rd) r_rd_cnt <= r_rd_cnt + 32'd1;
        if (w_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
      end

      r_outstanding <= w_rd;
      r_pipe_valid  <= w_accept;
      if (w_accept) r_pipe_data <= w_sum;

      if (r_pipe_valid) begin
        r_buf[r_wptr] <= r_pipe_data;
        r_wptr        <= w_wptr_next;
      end
      if (w_wr) r_rptr <= w_rptr_next;

      case ({r_pipe_valid, w_wr})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_start)      r_err <= 1'b0;
      else if (w_stray) r_err <= 1'b1;
    end
  end

  assign o_busy = (r_state == StRun);
  assign o_done = (r_state == StFin);
  assign o_err  = r_err;
  assign o_rd   = w_rd;
  assign o_wr   = w_wr;
  assign o_din  = r_buf[r_rptr];

endmodule

// File: tb/tb_sma_stream_add.sv
// Bench for sma_stream_add: FIFO-side driver feeds a scoreboard queue, a separate
// monitor pops and compares every written word against a per-lane addition model.
module tb_sma_stream_add;

  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         i_rst, i_start, i_vld, i_full;
  logic [31:0]  i_len, i_addend;
  logic [127:0] i_dout;
  logic         o_busy, o_done, o_err, o_rd, o_wr;
  logic [127:0] o_din;

  always #5 clk = ~clk;

  sma_stream_add #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .i_uclk   (clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_len    (i_len),
    .i_addend (i_addend),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err),
    .o_rd     (o_rd),
    .i_vld    (i_vld),
    .i_dout   (i_dout),
    .o_wr     (o_wr),
    .i_full   (i_full),
    .o_din    (o_din)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]  cur_addend = 32'd0;
  bit           stray_req  = 1'b0;
  logic [127:0] exp_q[$];
  logic [127:0] data_q[$];
  logic [127:0] din_q[$];
  int           rd_cyc_q[$];
  int           wr_cyc_q[$];
  int           done_cyc_q[$];
  int           busy_cnt = 0;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] ref_add(input logic [127:0] w, input logic [31:0] a);
    logic [127:0] r;
    logic [31:0]  lane;
    for (int i = 0; i < 4; i++) begin
      lane = w[32*i +: 32];
      r[32*i +: 32] = lane + a;
    end
    return r;
  endfunction

  function automatic int qi(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-FIFO model: data valid the cycle after rd; expected result queued on delivery.
  initial begin : driver
    logic         r, s;
    logic [127:0] w;
    i_vld  = 1'b0;
    i_dout = '0;
    forever begin
      @(negedge clk);
      r = o_rd && !i_rst;
      s = stray_req;
      @(posedge clk);
      #1;
      i_vld = r | s;
      if (r) begin
        w = (data_q.size() > 0) ? data_q.pop_front() : rand128();
        i_dout = w;
        exp_q.push_back(ref_add(w, cur_addend));
      end else begin
        i_dout = rand128();
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (o_rd) rd_cyc_q.push_back(cyc);
      if (o_busy) busy_cnt++;
      if (o_done) done_cyc_q.push_back(cyc);
      if (o_wr) begin
        wr_cyc_q.push_back(cyc);
        din_q.push_back(o_din);
        chk("wr_while_full", i_full, 1'b0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wr: got din %h expected no write", o_din);
        end else begin
          chk("din_order", o_din, exp_q.pop_front());
        end
      end
      if (i_rst) exp_q.delete();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] len, input logic [31:0] add, output int sc);
    @(posedge clk);
    #1;
    cur_addend = add;
    i_len      = len;
    i_addend   = add;
    i_start    = 1'b1;
    sc         = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int nd0, input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (done_cyc_q.size() > nd0) return;
    end
    total++;
    bad++;
    $display("FAIL %s: got no done after %0d cycles, required one done pulse", name, budget);
  endtask

  initial begin : main
    int sc, b_rd, b_wr, b_dn, b_busy, w5, len;
    logic [31:0] add;
    bit finished;

    i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_addend = '0; i_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err",  o_err,  1'b0);
    chk("rst_rd",   o_rd,   1'b0);
    chk("rst_wr",   o_wr,   1'b0);
    chk("rst_din",  o_din,  128'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    idle(2);

    // Lane carries must not cross lanes.
    b_rd = rd_cyc_q.size(); b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size(); b_busy = busy_cnt;
    data_q.push_back(128'h00000000_FFFFFFFF_00000005_7FFFFFFF);
    start_run(32'd3, 32'd1, sc);
    wait_done(b_dn, 50, "t1_done");
    idle(2);
    chk("t1_rd_count", rd_cyc_q.size() - b_rd, 3);
    chk("t1_wr_count", wr_cyc_q.size() - b_wr, 3);
    chk("t1_first_din", (din_q.size() > b_wr) ? din_q[b_wr] : '1,
        128'h00000001_00000000_00000006_80000000);
    chk("t1_done_after_wr", qi(done_cyc_q, b_dn), qi(wr_cyc_q, b_wr + 2) + 1);
    chk("t1_busy_cycles", busy_cnt - b_busy, 6);
    chk("t1_busy_low", o_busy, 1'b0);

    b_rd = rd_cyc_q.size(); b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size(); b_busy = busy_cnt;
    start_run(32'd0, 32'd7, sc);
    wait_done(b_dn, 20, "t2_done");
    idle(2);
    chk("t2_rd_count", rd_cyc_q.size() - b_rd, 0);
    chk("t2_wr_count", wr_cyc_q.size() - b_wr, 0);
    chk("t2_done_cycle", qi(done_cyc_q, b_dn), sc + 1);
    chk("t2_busy_cycles", busy_cnt - b_busy, 0);

    // Output stalled by full: reads must stop at DEPTH words in flight.
    b_rd = rd_cyc_q.size(); b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size();
    start_run(32'd16, 32'h10, sc);
    finished = 1'b0;
    w5 = 0;
    for (int n = 0; n < 300; n++) begin
      i_full = ((cyc - sc) >= 5) && ((cyc - sc) <= 20);
      @(negedge clk);
      #1;
      if (cyc - sc == 5) w5 = wr_cyc_q.size();
      if (cyc - sc == 20) begin
        chk("t3_wr_stalled", wr_cyc_q.size() - w5, 0);
        chk("t3_inflight", (rd_cyc_q.size() - b_rd) - (wr_cyc_q.size() - b_wr), DEPTH);
      end
      if (done_cyc_q.size() > b_dn) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    i_full = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL t3_done: got no done within 300 cycles, required one done pulse");
    end
    idle(2);
    chk("t3_rd_count", rd_cyc_q.size() - b_rd, 16);
    chk("t3_wr_count", wr_cyc_q.size() - b_wr, 16);
    chk("t3_exp_empty", exp_q.size(), 0);

    b_rd = rd_cyc_q.size(); b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size();
    start_run(32'd8, $urandom, sc);
    wait_done(b_dn, 60, "t4_done");
    idle(2);
    chk("t4_wr_count", wr_cyc_q.size() - b_wr, 8);
    chk("t4_rd_count", rd_cyc_q.size() - b_rd, 8);
    chk("t4_first_rd", qi(rd_cyc_q, b_rd), sc + 1);
    chk("t4_latency", qi(wr_cyc_q, b_wr), qi(rd_cyc_q, b_rd) + 3);
    chk("t4_back_to_back", qi(wr_cyc_q, b_wr + 7) - qi(wr_cyc_q, b_wr), 7);
    chk("t4_done_cycle", qi(done_cyc_q, b_dn), qi(wr_cyc_q, b_wr + 7) + 1);

    b_wr = wr_cyc_q.size();
    stray_req = 1'b1;
    @(negedge clk);
    #1;
    stray_req = 1'b0;
    idle(3);
    chk("t5_err_set", o_err, 1'b1);
    chk("t5_no_wr", wr_cyc_q.size() - b_wr, 0);
    b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size();
    start_run(32'd1, $urandom, sc);
    chk("t5_err_cleared", o_err, 1'b0);
    wait_done(b_dn, 30, "t5_done");
    idle(2);
    chk("t5_wr_count", wr_cyc_q.size() - b_wr, 1);

    b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size();
    start_run(32'd10, $urandom, sc);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (wr_cyc_q.size() - b_wr >= 2) break;
    end
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("t6_rd_low",   o_rd,   1'b0);
    chk("t6_wr_low",   o_wr,   1'b0);
    chk("t6_busy_low", o_busy, 1'b0);
    idle(5);
    chk("t6_no_done", done_cyc_q.size() - b_dn, 0);
    chk("t6_err_low", o_err, 1'b0);
    chk("t6_exp_flushed", exp_q.size(), 0);
    b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size();
    start_run(32'd1, $urandom, sc);
    wait_done(b_dn, 30, "t6_restart_done");
    idle(2);
    chk("t6_restart_wr", wr_cyc_q.size() - b_wr, 1);
    chk("t6_restart_exp_empty", exp_q.size(), 0);

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 24);
      add = $urandom;
      b_rd = rd_cyc_q.size(); b_wr = wr_cyc_q.size(); b_dn = done_cyc_q.size();
      start_run(len, add, sc);
      finished = 1'b0;
      for (int n = 0; n < 600; n++) begin
        i_full = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        #1;
        if (done_cyc_q.size() > b_dn) begin
          finished = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      i_full = 1'b0;
      if (!finished) begin
        total++;
        bad++;
        $display("FAIL rand_done: got no done within 600 cycles for len %0d", len);
      end
      idle(2);
      chk("rand_rd_count", rd_cyc_q.size() - b_rd, len);
      chk("rand_wr_count", wr_cyc_q.size() - b_wr, len);
      chk("rand_exp_empty", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish by 500000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sma_stream_add.md
Name: sma_stream_add

Overview:
- User-clock-domain stream engine directly downstream of the sequential memory access unit.
- Pops 128-bit words from the unit's read FIFO (rd/vld/dout) and adds a programmable 32-bit constant to each lane, modulo 2^32.
- Pushes results into the unit's write FIFO (wr/full/din).
- Processes a programmed word count per start, then pulses done.

Parameters:
LANES, 4, number of 32-bit lanes per word (data width = 32*LANES = 128)
DEPTH, 4, output buffer entries; bounds reads in flight plus results held

Ports:
uclk  in  1  clock (user clock domain); the only clock in the block
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; latches len and addend and begins a run (ignored while busy)
len  in  32  number of 128-bit words to process
addend  in  32  constant added to every 32-bit lane
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse when the last word is written
err  out  1  sticky; set by vld arriving with no read outstanding; cleared by rst or accepted start
rd  out  1  read-FIFO read enable
vld  in  1  read-FIFO data valid, one cycle after rd
dout  in  128  read-FIFO data
wr  out  1  write-FIFO write enable
full  in  1  write-FIFO full
din  out  128  write-FIFO data

Behaviour:
- Reset values: busy=0, done=0, err=0, rd=0, wr=0, din=0. All counters and the buffer are cleared.
- Reset mid-run abandons the run. No further rd/wr. Returns to IDLE.
- States:
  - IDLE: on start, latch len/addend, clear err, go to RUN. If len==0, go to FIN instead.
  - RUN: issue reads and writes. When wr_cnt reaches len, go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- busy is 1 in RUN only. start in RUN or FIN is ignored.
- Read issue: rd=1 when state==RUN && rd_cnt<len && (outstanding + pipe_valid + buf_count) < DEPTH.
  - outstanding = rd issued last cycle (0 or 1).
  - rd_cnt increments per rd. rd never exceeds len total.
- Compute stage: on vld with a read outstanding, register per lane i: dout[32i+31:32i] + addend (carry discarded, no lane crosses). Sets pipe_valid.
- Stray vld (no read outstanding): data discarded, err set, counters unchanged.
- Buffer: pipe register moves into a DEPTH-entry FIFO buffer on the next cycle.
  - The issue condition guarantees the buffer never overflows.
- Write: wr = buf_count>0 && !full. din = buffer head, stable while wr=0. wr_cnt increments per wr.
  - wr is never asserted while full=1.
  - full rising with data buffered stalls wr only. Reads keep issuing until the occupancy bound is hit.
- Latency: rd at cycle t gives vld at t+1, pipe at t+2, buffer at t+3, earliest wr at t+3.
- Throughput: one word per cycle sustained when full=0 and vld follows every rd.
- Order: output word order equals input word order.
- Width: rd_cnt and wr_cnt are 32 bits. len=0xFFFFFFFF must complete with no counter wrap before compare.
- Same-cycle buffer push and pop leaves buf_count unchanged.

Test Plan:
- len=3, addend=1, dout words 0x00000000_FFFFFFFF_00000005_7FFFFFFF and two more, full=0 -> three wr, first din=0x00000001_00000000_00000006_80000000; exactly 3 rd; done one cycle after third wr; busy 1→0.
- len=0, start -> no rd, no wr, done pulse one cycle after start, busy never high.
- len=16, addend=0x10, full held high cycles 5–20 -> wr=0 throughout the stall; rd stops after outstanding+pipe+buffer reaches 4; all 16 words written in order afterwards with +0x10 per lane.
- Back-to-back: len=8, vld every cycle after rd, full=0 -> 8 consecutive wr cycles; first wr 3 cycles after first rd.
- vld pulse while IDLE -> err=1, no wr; next accepted start clears err.
- rst asserted mid-run after 2 of 10 words -> next cycle rd=wr=busy=0, no done; new start with len=1 completes normally.
